// File: rtl/accum_stack.sv
// accum_stack: WIDTH-bit accumulator with an on-register operation set and a
// DEPTH-entry save/restore LIFO for nested call and interrupt context.
// Every operation commits on the rising edge where it is sampled; flags that
// are derived from registers (zero, neg, full, empty) are combinational.
module accum_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  output logic [WIDTH-1:0] acc_out,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_CLR  = 3'b010,
    OP_INC  = 3'b011,
    OP_DEC  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_ADD  = 3'b111
  } op_e;

  // Result of the accumulator operation, before the LIFO gets a say.
  typedef struct packed {
    logic [WIDTH-1:0] acc;
    logic             carry;
  } op_res_t;

  logic [WIDTH-1:0]            acc_q, acc_d;
  logic                        carry_q, carry_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        err_q, err_d;
  logic [DEPTH-1:0][WIDTH-1:0] lifo_q, lifo_d;

  op_res_t          op_res;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] top_val;
  logic [CW-1:0]    top_idx;
  logic             is_full, is_empty;
  logic             new_err;

  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign top_idx  = count_q - CW'(1);

  // Accumulator operation unit: computes the op's acc/carry from current state.
  always_comb begin
    op_res.acc   = acc_q;
    op_res.carry = carry_q;
    sum          = '0;
    if (en) begin
      case (op_e'(op))
        OP_HOLD: ;
        OP_LOAD: op_res.acc = din;
        OP_CLR: begin
          op_res.acc   = '0;
          op_res.carry = 1'b0;
        end
        OP_INC: begin
          sum          = {1'b0, acc_q} + {{WIDTH{1'b0}}, 1'b1};
          op_res.acc   = sum[WIDTH-1:0];
          op_res.carry = sum[WIDTH];
        end
        OP_DEC: begin
          op_res.acc   = acc_q - {{(WIDTH-1){1'b0}}, 1'b1};
          op_res.carry = (acc_q == '0);
        end
        OP_SHL: begin
          op_res.acc   = {acc_q[WIDTH-2:0], 1'b0};
          op_res.carry = acc_q[WIDTH-1];
        end
        OP_SHR: begin
          op_res.acc   = {1'b0, acc_q[WIDTH-1:1]};
          op_res.carry = acc_q[0];
        end
        OP_ADD: begin
          sum          = {1'b0, acc_q} + {1'b0, din};
          op_res.acc   = sum[WIDTH-1:0];
          op_res.carry = sum[WIDTH];
        end
        default: ;
      endcase
    end
  end

  // Read mux for the LIFO top; a compare loop keeps the index width independent
  // of whether DEPTH is a power of two.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == top_idx) top_val = lifo_q[i];
    end
  end

  // Next-state: op result by default, then push/pop/swap override and error tracking.
  always_comb begin
    acc_d   = op_res.acc;
    carry_d = op_res.carry;
    count_d = count_q;
    lifo_d  = lifo_q;
    new_err = 1'b0;
    case ({push, pop})
      2'b10: begin
        // Saved value is the pre-op accumulator; the op still lands in acc.
        if (!is_full) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == count_q) lifo_d[i] = acc_q;
          end
          count_d = count_q + CW'(1);
        end else begin
          new_err = 1'b1;
        end
      end
      2'b01: begin
        // Restore wins over the op for acc, and the op's carry is dropped.
        if (!is_empty) begin
          acc_d   = top_val;
          carry_d = carry_q;
          count_d = top_idx;
        end else begin
          new_err = 1'b1;
        end
      end
      2'b11: begin
        // Swap acc with the top entry; the op is ignored entirely.
        if (!is_empty) begin
          acc_d   = top_val;
          carry_d = carry_q;
          for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == top_idx) lifo_d[i] = acc_q;
          end
        end else begin
          new_err = 1'b1;
        end
      end
      default: ;
    endcase
    // A fresh error beats a clear request in the same cycle.
    if (new_err)      err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
    else              err_d = err_q;
  end

  // Architectural state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // LIFO storage; contents are meaningless once count is reset, so no reset here.
  always_ff @(posedge clk) begin
    lifo_q <= lifo_d;
  end

  assign acc_out = acc_q;
  assign carry   = carry_q;
  assign zero    = (acc_q == '0);
  assign neg     = acc_q[WIDTH-1];
  assign count   = count_q;
  assign full    = is_full;
  assign empty   = is_empty;
  assign err     = err_q;

endmodule
